// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

    localparam int MUL_DEFAULT_WIDTH = 32;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int mul_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Magnitude of a two's-complement value when enabled, pass-through otherwise.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_magnitude
);

    // The most-negative input maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign o_magnitude = (i_enable && i_value[WIDTH-1]) ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, signed or unsigned,
// with valid/ready handshakes on both sides.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_is_signed,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int            CW       = mul_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mul_state_t         r_state;
    mul_state_t         w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_acc;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_zero;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_prod_final;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_value    (i_a),
        .i_enable   (i_is_signed),
        .o_magnitude(w_abs_a)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_value    (i_b),
        .i_enable   (i_is_signed),
        .o_magnitude(w_abs_b)
    );

    assign w_zero = (i_a == '0) || (i_b == '0);
    assign w_last = (r_cnt == CNT_ONE);

    // Low half of r_acc doubles as the multiplier shift register; its LSB gates the add.
    assign w_sum        = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand}) : r_acc[2*WIDTH:WIDTH];
    assign w_acc_next   = {1'b0, w_sum, r_acc[WIDTH-1:1]};
    assign w_prod_final = r_neg ? ({(2*WIDTH){1'b0}} - w_acc_next[2*WIDTH-1:0])
                                : w_acc_next[2*WIDTH-1:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_next_state = w_zero ? DONE : CALC;
            CALC:    if (w_last) w_next_state = DONE;
            DONE:    if (i_out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_mcand <= w_abs_a;
                        r_acc   <= {1'b0, {WIDTH{1'b0}}, w_abs_b};
                        r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_cnt   <= CNT_LOAD;
                        if (w_zero) r_product <= '0;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) r_product <= w_prod_final;
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_product   = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a WIDTH=32 instance for directed scenarios
// and a WIDTH=8 instance for a randomised sweep against the native * operator.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rstN;

    logic        inValid32, inReady32, isSigned32, outValid32, outReady32;
    logic [31:0] a32, b32;
    logic [63:0] product32;

    logic        inValid8, inReady8, isSigned8, outValid8, outReady8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] expQ32[$];
    logic [15:0] expQ8[$];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_in_valid(inValid32), .o_in_ready(inReady32),
        .i_a(a32), .i_b(b32), .i_is_signed(isSigned32),
        .o_out_valid(outValid32), .i_out_ready(outReady32),
        .o_product(product32)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_in_valid(inValid8), .o_in_ready(inReady8),
        .i_a(a8), .i_b(b8), .i_is_signed(isSigned8),
        .o_out_valid(outValid8), .i_out_ready(outReady8),
        .o_product(product8)
    );

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = s ? {{32{a[31]}}, a} : {32'b0, a};
        sb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        sa = s ? {{8{a[7]}}, a} : {8'b0, a};
        sb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return sa * sb;
    endfunction

    // Drive one accepted operation, scramble the operands after the accept edge,
    // then wait (bounded) for out_valid; lat counts the DONE cycle as cycle lat.
    task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic [63:0] expected,
                                   output logic [63:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!inReady32 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a32 = a; b32 = b; isSigned32 = s; inValid32 = 1'b1;
        expQ32.push_back(expected);
        @(posedge clk); #1;
        inValid32 = 1'b0; a32 = $urandom; b32 = $urandom; isSigned32 = ~s;
        lat = 1;
        while (!outValid32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product32;
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [15:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!inReady8 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a8 = a; b8 = b; isSigned8 = s; inValid8 = 1'b1;
        expQ8.push_back(ref8(a, b, s));
        @(posedge clk); #1;
        inValid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); isSigned8 = ~s;
        lat = 1;
        while (!outValid8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product8;
    endtask

    task automatic releaseOutput32();
        outReady32 = 1'b1;
        @(posedge clk); #1;
        outReady32 = 1'b0;
    endtask

    task automatic releaseOutput8();
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (inReady32 !== 1'b1 || outValid32 !== 1'b0 || product32 !== 64'h0) begin
            $display("[TB] FAIL reset32: in_ready=%b out_valid=%b product=%h, required 1 0 0",
                     inReady32, outValid32, product32);
            miscompares++;
        end
        vectors++;
        if (inReady8 !== 1'b1 || outValid8 !== 1'b0 || product8 !== 16'h0) begin
            $display("[TB] FAIL reset8: in_ready=%b out_valid=%b product=%h, required 1 0 0",
                     inReady8, outValid8, product8);
            miscompares++;
        end
    endtask

    // Directed operand/result table; each entry must finish in WIDTH+1 cycles.
    task automatic runTable32(input string name, input logic s,
                              input logic [31:0] av[3], input logic [31:0] bv[3],
                              input logic [63:0] pv[3]);
        logic [63:0] prod, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            applyStimulus32(av[i], bv[i], s, pv[i], prod, lat);
            exp = expQ32.pop_front();
            vectors++;
            if (prod !== exp) begin
                $display("[TB] FAIL %s_product[%0d]: got %h required %h", name, i, prod, exp);
                miscompares++;
            end
            vectors++;
            if (lat !== 33) begin
                $display("[TB] FAIL %s_latency[%0d]: got %0d required 33", name, i, lat);
                miscompares++;
            end
            releaseOutput32();
            vectors++;
            if (inReady32 !== 1'b1 || outValid32 !== 1'b0) begin
                $display("[TB] FAIL %s_idle[%0d]: in_ready=%b out_valid=%b required 1 0",
                         name, i, inReady32, outValid32);
                miscompares++;
            end
        end
    endtask

    task automatic test_unsigned();
        runTable32("unsigned", 1'b0,
                   '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1000_0000},
                   '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1000_0000},
                   '{64'h1, 64'hFFFF_FFFE_0000_0001, 64'h0100_0000_0000_0000});
    endtask

    task automatic test_signed();
        runTable32("signed", 1'b1,
                   '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000},
                   '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000},
                   '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h4000_0000_0000_0000});
    endtask

    task automatic test_zero();
        logic [31:0] av[2] = '{32'h0, 32'h1234_5678};
        logic [31:0] bv[2] = '{32'h1234_5678, 32'h0};
        logic [63:0] prod, exp;
        int lat;
        for (int i = 0; i < 2; i++) begin
            applyStimulus32(av[i], bv[i], i[0], 64'h0, prod, lat);
            exp = expQ32.pop_front();
            vectors++;
            if (prod !== exp) begin
                $display("[TB] FAIL zero_product[%0d]: got %h required %h", i, prod, exp);
                miscompares++;
            end
            vectors++;
            if (lat !== 1) begin
                $display("[TB] FAIL zero_latency[%0d]: got %0d required 1", i, lat);
                miscompares++;
            end
            releaseOutput32();
        end
    endtask

    // Stall DONE for ten cycles while offering new operands that must be ignored.
    task automatic test_backpressure();
        logic [63:0] prod, exp;
        int lat;
        applyStimulus32(32'hDEAD_BEEF, 32'h0000_1235, 1'b1, ref32(32'hDEAD_BEEF, 32'h0000_1235, 1'b1), prod, lat);
        exp = expQ32.pop_front();
        vectors++;
        if (prod !== exp) begin
            $display("[TB] FAIL backpressure_product: got %h required %h", prod, exp);
            miscompares++;
        end
        for (int c = 0; c < 10; c++) begin
            inValid32 = (c == 2 || c == 3);
            a32 = 32'h0000_FFFF; b32 = 32'h0000_FFFF; isSigned32 = 1'b0;
            vectors++;
            if (outValid32 !== 1'b1 || inReady32 !== 1'b0 || product32 !== exp) begin
                $display("[TB] FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b product=%h, required 1 0 %h",
                         c, outValid32, inReady32, product32, exp);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        inValid32 = 1'b0;
        releaseOutput32();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (outValid32 !== 1'b0 || inReady32 !== 1'b1) begin
                $display("[TB] FAIL backpressure_ghost[%0d]: out_valid=%b in_ready=%b required 0 1",
                         c, outValid32, inReady32);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] prod, exp;
        int lat;
        int seen;
        a32 = 32'h0F0F_0F0F; b32 = 32'h00FF_00FF; isSigned32 = 1'b0; inValid32 = 1'b1;
        @(posedge clk); #1;
        inValid32 = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rstN = 1'b0;
        #1;
        vectors++;
        if (inReady32 !== 1'b1 || outValid32 !== 1'b0 || product32 !== 64'h0) begin
            $display("[TB] FAIL reset_mid_calc: in_ready=%b out_valid=%b product=%h, required 1 0 0",
                     inReady32, outValid32, product32);
            miscompares++;
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (outValid32) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 0) begin
            $display("[TB] FAIL reset_discard: got %0d out_valid cycles required 0", seen);
            miscompares++;
        end
        applyStimulus32(32'd2, 32'd3, 1'b0, 64'd6, prod, lat);
        exp = expQ32.pop_front();
        vectors++;
        if (prod !== exp || lat !== 33) begin
            $display("[TB] FAIL reset_recover: product=%h latency=%0d required %h 33", prod, lat, exp);
            miscompares++;
        end
        releaseOutput32();
    endtask

    // out_ready tied high with in_valid held: accept-to-accept spacing is WIDTH+2.
    task automatic test_back_to_back();
        int n;
        int lat;
        bit got1;
        logic [63:0] exp;
        outReady32 = 1'b1;
        a32 = 32'h0001_0003; b32 = 32'h0000_0007; isSigned32 = 1'b0; inValid32 = 1'b1;
        expQ32.push_back(ref32(32'h0001_0003, 32'h0000_0007, 1'b0));
        @(posedge clk); #1;
        a32 = 32'hFFFF_FFF0; b32 = 32'h0000_0021; isSigned32 = 1'b1;
        expQ32.push_back(ref32(32'hFFFF_FFF0, 32'h0000_0021, 1'b1));
        n = 1;
        got1 = 1'b0;
        while (!inReady32 && n < 100) begin
            if (outValid32) begin
                got1 = 1'b1;
                exp = expQ32.pop_front();
                vectors++;
                if (product32 !== exp) begin
                    $display("[TB] FAIL b2b_first_product: got %h required %h", product32, exp);
                    miscompares++;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n !== 34 || !got1) begin
            $display("[TB] FAIL b2b_period: got %0d cycles (result seen=%0d) required 34 (1)", n, got1);
            miscompares++;
        end
        @(posedge clk); #1;
        inValid32 = 1'b0;
        lat = 1;
        while (!outValid32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = expQ32.pop_front();
        vectors++;
        if (product32 !== exp || lat !== 33) begin
            $display("[TB] FAIL b2b_second: product=%h latency=%0d required %h 33", product32, lat, exp);
            miscompares++;
        end
        @(posedge clk); #1;
        outReady32 = 1'b0;
    endtask

    task automatic test_sweep8();
        logic [7:0]  av[3] = '{8'h80, 8'h80, 8'hFF};
        logic [7:0]  bv[3] = '{8'h80, 8'h7F, 8'hFF};
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] prod, exp;
        int lat, expLat;
        for (int i = 0; i < 40; i++) begin
            if (i < 3) begin
                a = av[i]; b = bv[i]; s = (i < 2);
            end else begin
                a = 8'($urandom); b = 8'($urandom); s = i[0];
                if (i % 9 == 0) a = 8'h00;
                if (i % 11 == 0) b = 8'h00;
            end
            expLat = (a == 8'h0 || b == 8'h0) ? 1 : 9;
            applyStimulus8(a, b, s, prod, lat);
            exp = expQ8.pop_front();
            vectors++;
            if (prod !== exp || lat !== expLat) begin
                $display("[TB] FAIL sweep8[%0d] a=%h b=%h s=%b: product=%h latency=%0d required %h %0d",
                         i, a, b, s, prod, lat, exp, expLat);
                miscompares++;
            end
            releaseOutput8();
        end
    endtask

    initial begin
        rstN = 1'b0;
        inValid32 = 1'b0; outReady32 = 1'b0; a32 = '0; b32 = '0; isSigned32 = 1'b0;
        inValid8  = 1'b0; outReady8  = 1'b0; a8  = '0; b8  = '0; isSigned8  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstN = 1'b1;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_sweep8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
